regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the fixed 32x32, 4-read/4-write core file.
- Width, depth, read-port count and write-port count are configurable.
- Adds the following, none of which the current file has:
  - deterministic write-collision priority
  - optional write-to-read bypass
  - hardwired zero register
  - per-register busy scoreboard with reserve/release
  - registered collision flag
- Sits in the execute/writeback boundary; the issue logic uses the busy outputs for hazard stalls.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; ADDR_W = $clog2(DEPTH).
- NUM_RD, 4, number of read ports.
- NUM_WR, 4, number of write ports.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored contents.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  busy bit of the addressed register, combinational.
- wr_en  in  NUM_WR  write enables, one bit per port.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  reserve request: marks rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- wr_conflict  out  1  registered pulse: two or more write ports hit the same register in the previous cycle.
- busy_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (async, rst_n=0), applied immediately, independent of clk:
  - all registers = 0, all busy bits = 0
  - wr_conflict = 0, busy_cnt = 0
  - rd_data reads 0 while in reset.
- Release of reset takes effect at the next rising clk edge.
- Writes commit on rising clk: storage updates one cycle after wr_en is sampled.
- Write collision:
  - If several enabled ports target the same address, the highest-indexed port wins.
  - Lower ports to that address are discarded.
  - Ports to different addresses all commit in the same cycle.
- wr_conflict:
  - Set to 1 on the edge after any cycle with ≥2 enabled ports on the same address, else 0.
  - Collisions on register 0 with ZERO_REG=1 do not count.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - rd_data for address 0 = 0, rd_busy = 0.
  - rsv_en to address 0 is ignored.
- Read with BYPASS=1:
  - If any enabled write port targets rd_addr this cycle, rd_data = the winning port's wr_data.
  - Otherwise rd_data = stored value.
- Read with BYPASS=0: rd_data = stored value only.
- Out-of-range addresses (DEPTH not a power of 2):
  - Reads return 0.
  - Writes and reserves are ignored.
- Scoreboard:
  - busy[r] is set on an edge where rsv_en=1 and rsv_addr=r.
  - busy[r] is cleared on an edge where any enabled write port targets r.
  - If reserve and write hit the same r in the same cycle, the reserve wins and busy stays 1 (new producer supersedes the old one).
  - Reserving an already-busy register keeps it at 1; no error.
- rd_busy:
  - BYPASS=1: rd_busy = busy[addr] AND NOT (write to addr this cycle).
  - BYPASS=0: rd_busy = busy[addr].
- busy_cnt:
  - Popcount of the busy bits, registered; reflects the busy state after the same edge.
  - Range 0..DEPTH; with ZERO_REG=1 the maximum is DEPTH-1.
- No backpressure: every write is accepted every cycle; there is no ready signal.

Test Plan:
- Reset state:
  - Load r5=0xDEADBEEF, then pulse rst_n low mid-cycle.
  - Required: all rd_data=0, busy_cnt=0, wr_conflict=0 immediately, without waiting for a clk edge.
- Collision priority:
  - Same cycle: port0 writes r7=0x11, port3 writes r7=0x33.
  - Required next cycle: r7 reads 0x33, wr_conflict=1 for exactly one cycle, then 0.
- Bypass:
  - BYPASS=1, r9 holds 0xAAAA; port1 writes r9=0x5555 while rd port2 reads r9.
  - Required: rd_data2=0x5555 in the same cycle.
  - Repeat with BYPASS=0: required rd_data2=0xAAAA that cycle, 0x5555 the next.
- Zero register:
  - Write r0=0xFFFFFFFF, reserve r0.
  - Required: read r0=0, rd_busy=0, busy_cnt unchanged; no wr_conflict when two ports write r0.
- Scoreboard:
  - Reserve r3 -> busy_cnt=1, rd_busy on r3=1 next cycle.
  - Write r3 while also reserving r3 -> busy stays 1.
  - Write r3 alone -> busy_cnt=0.
- Parametrisation:
  - Instantiate DATA_W=64, DEPTH=48, NUM_RD=6, NUM_WR=2.
  - Write r47 = 0x0123456789ABCDEF, write r50 -> r47 reads back 0x0123456789ABCDEF; the r50 write is ignored and its read returns 0.
  - Reserve all 47 non-zero registers -> busy_cnt=47.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write ports, reserve port and status.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 4
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     wr_conflict;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, wr_conflict, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, wr_conflict, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write priority, optional bypass,
// hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 4,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  rsv_hit;
    logic              conflict_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              conflict_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Address is backed by a real, writable register (in range, not the zero register)
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Per-register write winner (highest port wins), collision detect and next busy state
    always_comb begin
        wr_hit       = '0;
        rsv_hit      = '0;
        conflict_nxt = 1'b0;
        cnt_nxt      = '0;
        wa           = '0;
        for (int r = 0; r < int'(DEPTH); r++) begin
            wr_val[r] = '0;
            for (int w = 0; w < int'(NUM_WR); w++) begin
                wa = bus.wr_addr[w*ADDR_W +: ADDR_W];
                if (bus.wr_en[w] && addr_ok(wa) && (wa == ADDR_W'(r))) begin
                    if (wr_hit[r]) begin
                        conflict_nxt = 1'b1;
                    end
                    wr_hit[r] = 1'b1;
                    wr_val[r] = bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
            rsv_hit[r] = bus.rsv_en && addr_ok(bus.rsv_addr) && (bus.rsv_addr == ADDR_W'(r));
        end
        // A reserve in the same cycle as the write names a newer producer, so it wins
        busy_nxt = (busy & ~wr_hit) | rsv_hit;
        for (int r = 0; r < int'(DEPTH); r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    // Read ports: stored value, or same-cycle winning write data when bypass is enabled
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
            if (rst_n && addr_ok(ra)) begin
                for (int r = 0; r < int'(DEPTH); r++) begin
                    if (ra == ADDR_W'(r)) begin
                        rd_data_c[p*DATA_W +: DATA_W] = mem[r];
                        rd_busy_c[p]                  = busy[r];
                        if ((BYPASS != 0) && wr_hit[r]) begin
                            rd_data_c[p*DATA_W +: DATA_W] = wr_val[r];
                            rd_busy_c[p]                  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Storage, scoreboard and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem[r] <= '0;
            end
            busy       <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                if (wr_hit[r]) begin
                    mem[r] <= wr_val[r];
                end
            end
            busy       <= busy_nxt;
            conflict_q <= conflict_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.wr_conflict = conflict_q;
    assign bus.busy_cnt    = cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass, no-bypass and wide/non-pow2 instances.
module tb_regfile_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(4)) ia ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(4)) ib ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(6), .NUM_RD(6), .NUM_WR(2)) ic ();

    regfile_mp #(.BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    regfile_mp #(.BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    regfile_mp #(.DATA_W(64), .DEPTH(48), .NUM_RD(6), .NUM_WR(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    typedef struct {
        string       name;
        logic [3:0]  we;
        logic [4:0]  wa0, wa1, wa2, wa3;
        logic [31:0] wd0, wd1, wd2, wd3;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  rd;
        logic [31:0] exp_rd;
        logic        exp_busy;
        logic [5:0]  exp_cnt;
        logic        exp_conf;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkv(input string nm, input logic [3:0] we,
                                 input int wa0, input logic [31:0] wd0,
                                 input int wa1, input logic [31:0] wd1,
                                 input int wa2, input logic [31:0] wd2,
                                 input int wa3, input logic [31:0] wd3,
                                 input int rsv, input int ra, input int rd,
                                 input logic [31:0] erd, input int ebusy,
                                 input int ecnt, input int econf);
        vec_t v;
        v.name = nm;  v.we = we;
        v.wa0 = 5'(wa0); v.wa1 = 5'(wa1); v.wa2 = 5'(wa2); v.wa3 = 5'(wa3);
        v.wd0 = wd0; v.wd1 = wd1; v.wd2 = wd2; v.wd3 = wd3;
        v.rsv = 1'(rsv); v.ra = 5'(ra); v.rd = 5'(rd);
        v.exp_rd = erd; v.exp_busy = 1'(ebusy); v.exp_cnt = 6'(ecnt); v.exp_conf = 1'(econf);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rsv_en = 1'b0; ia.rsv_addr = '0; ia.rd_addr = '0;
        ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.rsv_en = 1'b0; ib.rsv_addr = '0; ib.rd_addr = '0;
        ic.wr_en = '0; ic.wr_addr = '0; ic.wr_data = '0; ic.rsv_en = 1'b0; ic.rsv_addr = '0; ic.rd_addr = '0;
    endtask

    task automatic apply_a(input vec_t v);
        ia.wr_en    = v.we;
        ia.wr_addr  = {v.wa3, v.wa2, v.wa1, v.wa0};
        ia.wr_data  = {v.wd3, v.wd2, v.wd1, v.wd0};
        ia.rsv_en   = v.rsv;
        ia.rsv_addr = v.ra;
        ia.rd_addr  = {v.rd, v.rd, v.rd, v.rd};
    endtask

    initial begin
        //            name           we      wa0 wd0            wa1 wd1            wa2 wd2       wa3 wd3     rsv ra rd  exp_rd         bsy cnt conf
        tbl[0]  = mkv("ld_r9",       4'b0001, 9, 32'hAAAA,      0, 0,              0, 0,         0, 0,       0, 0, 9,  32'hAAAA,      0, 0, 0);
        tbl[1]  = mkv("byp_r9",      4'b0010, 0, 0,             9, 32'h5555,       0, 0,         0, 0,       0, 0, 9,  32'h5555,      0, 0, 0);
        tbl[2]  = mkv("hold_r9",     4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 9,  32'h5555,      0, 0, 0);
        tbl[3]  = mkv("coll_r7",     4'b1001, 7, 32'h11,        0, 0,              0, 0,         7, 32'h33,  0, 0, 7,  32'h33,        0, 0, 1);
        tbl[4]  = mkv("hold_r7",     4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 7,  32'h33,        0, 0, 0);
        tbl[5]  = mkv("zero_wr",     4'b0011, 0, 32'hFFFFFFFF,  0, 32'hFFFFFFFF,   0, 0,         0, 0,       1, 0, 0,  32'h0,         0, 0, 0);
        tbl[6]  = mkv("rsv_r3",      4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       1, 3, 3,  32'h0,         0, 1, 0);
        tbl[7]  = mkv("busy_r3",     4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 3,  32'h0,         1, 1, 0);
        tbl[8]  = mkv("wr_rsv_r3",   4'b0100, 0, 0,             0, 0,              3, 32'h3333,  0, 0,       1, 3, 3,  32'h3333,      0, 1, 0);
        tbl[9]  = mkv("still_busy",  4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 3,  32'h3333,      1, 1, 0);
        tbl[10] = mkv("wr_r3",       4'b0010, 0, 0,             3, 32'h4444,       0, 0,         0, 0,       0, 0, 3,  32'h4444,      0, 0, 0);
        tbl[11] = mkv("rsv_r4",      4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       1, 4, 4,  32'h0,         0, 1, 0);
        tbl[12] = mkv("rsv_r4_again",4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       1, 4, 4,  32'h0,         1, 1, 0);
        tbl[13] = mkv("rsv3_wr4",    4'b0001, 4, 32'h4,         0, 0,              0, 0,         0, 0,       1, 3, 4,  32'h4,         0, 1, 0);
        tbl[14] = mkv("four_addr",   4'b1111, 10, 32'hA,        11, 32'hB,         12, 32'hC,    13, 32'hD,  0, 0, 12, 32'hC,         0, 1, 0);
        tbl[15] = mkv("rd_r10",      4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 10, 32'hA,         0, 1, 0);
        tbl[16] = mkv("rd_r13",      4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 13, 32'hD,         0, 1, 0);
        tbl[17] = mkv("rd_r3",       4'b0000, 0, 0,             0, 0,              0, 0,         0, 0,       0, 0, 3,  32'h4444,      1, 1, 0);

        idle_all();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt", 64'(ia.busy_cnt), 64'(0));
        rst_n = 1'b1;
        tick();

        // Reset sequence: load state, then assert reset mid-cycle
        ia.wr_en   = 4'b0111;
        ia.wr_addr = {5'd0, 5'd6, 5'd6, 5'd5};
        ia.wr_data = {32'h0, 32'h2, 32'h1, 32'hDEADBEEF};
        ia.rsv_en  = 1'b1;
        ia.rsv_addr = 5'd8;
        tick();
        idle_all();
        ia.rd_addr = {4{5'd5}};
        #1;
        chk("pre_rst_conf", 64'(ia.wr_conflict), 64'(1));
        chk("pre_rst_cnt", 64'(ia.busy_cnt), 64'(1));
        chk("pre_rst_r5", 64'(ia.rd_data[31:0]), 64'(32'hDEADBEEF));
        ia.wr_en   = 4'b0001;
        ia.wr_addr = {5'd0, 5'd0, 5'd0, 5'd5};
        ia.wr_data = {96'h0, 32'h12345678};
        #1;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rst_rd_data%0d", p), 64'(ia.rd_data[p*32 +: 32]), 64'(0));
        end
        chk("rst_busy_cnt", 64'(ia.busy_cnt), 64'(0));
        chk("rst_conflict", 64'(ia.wr_conflict), 64'(0));
        idle_all();
        tick();
        rst_n = 1'b1;
        tick();
        ia.rd_addr = {4{5'd5}};
        #1;
        chk("post_rst_r5", 64'(ia.rd_data[31:0]), 64'(0));
        tick();

        // Table-driven sequence on the bypass instance
        for (int i = 0; i < 18; i++) begin
            apply_a(tbl[i]);
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("%s_rd%0d", tbl[i].name, p), 64'(ia.rd_data[p*32 +: 32]), 64'(tbl[i].exp_rd));
                chk($sformatf("%s_busy%0d", tbl[i].name, p), 64'(ia.rd_busy[p]), 64'(tbl[i].exp_busy));
            end
            tick();
            chk($sformatf("%s_cnt", tbl[i].name), 64'(ia.busy_cnt), 64'(tbl[i].exp_cnt));
            chk($sformatf("%s_conf", tbl[i].name), 64'(ia.wr_conflict), 64'(tbl[i].exp_conf));
        end
        idle_all();

        // No-bypass instance: reads see stored contents until the edge
        ib.wr_en   = 4'b0001;
        ib.wr_addr = {15'd0, 5'd9};
        ib.wr_data = {96'h0, 32'hAAAA};
        tick();
        ib.wr_en   = 4'b0010;
        ib.wr_addr = {10'd0, 5'd9, 5'd0};
        ib.wr_data = {64'h0, 32'h5555, 32'h0};
        ib.rd_addr = {4{5'd9}};
        #1;
        chk("nobyp_same_cycle", 64'(ib.rd_data[2*32 +: 32]), 64'(32'hAAAA));
        tick();
        ib.wr_en = '0;
        #1;
        chk("nobyp_next_cycle", 64'(ib.rd_data[2*32 +: 32]), 64'(32'h5555));
        ib.rsv_en   = 1'b1;
        ib.rsv_addr = 5'd5;
        tick();
        ib.rsv_en  = 1'b0;
        ib.wr_en   = 4'b0001;
        ib.wr_addr = {15'd0, 5'd5};
        ib.wr_data = {96'h0, 32'h77};
        ib.rd_addr = {4{5'd5}};
        #1;
        chk("nobyp_busy_during_wr", 64'(ib.rd_busy[2]), 64'(1));
        chk("nobyp_cnt_rsv", 64'(ib.busy_cnt), 64'(1));
        tick();
        ib.wr_en = '0;
        #1;
        chk("nobyp_cnt_cleared", 64'(ib.busy_cnt), 64'(0));
        chk("nobyp_busy_cleared", 64'(ib.rd_busy[2]), 64'(0));
        idle_all();

        // Wide, non-power-of-two instance
        ic.wr_en   = 2'b11;
        ic.wr_addr = {6'd50, 6'd47};
        ic.wr_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
        tick();
        ic.wr_en   = '0;
        ic.rd_addr = {6'd50, 6'd0, 6'd0, 6'd0, 6'd0, 6'd47};
        #1;
        chk("c_r47", ic.rd_data[63:0], 64'h0123_4567_89AB_CDEF);
        chk("c_r50", ic.rd_data[5*64 +: 64], 64'h0);
        chk("c_r0", ic.rd_data[64 +: 64], 64'h0);
        chk("c_no_conf", 64'(ic.wr_conflict), 64'(0));
        ic.wr_en   = 2'b11;
        ic.wr_addr = {6'd20, 6'd20};
        ic.wr_data = {64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        tick();
        ic.wr_en   = '0;
        ic.rd_addr = {6'd0, 6'd0, 6'd0, 6'd0, 6'd20, 6'd0};
        #1;
        chk("c_coll_r20", ic.rd_data[64 +: 64], 64'h2222_0000_0000_0002);
        chk("c_coll_conf", 64'(ic.wr_conflict), 64'(1));
        for (int r = 1; r <= 47; r++) begin
            ic.rsv_en   = 1'b1;
            ic.rsv_addr = 6'(r);
            tick();
        end
        chk("c_cnt_47", 64'(ic.busy_cnt), 64'(47));
        ic.rsv_addr = 6'd0;
        tick();
        ic.rsv_addr = 6'd50;
        tick();
        ic.rsv_en = 1'b0;
        #1;
        chk("c_cnt_still_47", 64'(ic.busy_cnt), 64'(47));
        chk("c_conf_cleared", 64'(ic.wr_conflict), 64'(0));
        idle_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
